// File: rtl/queue_pkg.sv
// Shared constants and helpers for the parametrised queue.
// Default geometry plus pointer-width helper.
package queue_pkg;

  localparam int QUEUE_WIDTH = 8;
  localparam int QUEUE_DEPTH = 8;
  localparam int QUEUE_LEN_W = 8;

  // A one-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register array backing the queue.
// Ports: clk, we/wr_addr/wr_data (sync write), rd_addr/rd_data (indexed read).
module queue_mem
  import queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int PW    = ptr_w(QUEUE_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: empty blocks every stale read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_queue.sv
// Parametrised synchronous FIFO with flags, error pulses and flush.
// Ports: clock_10, reset, data_in, enq_in, deq_in, clear_in -> data_out,
//        len_out, full_out, empty_out, ovf_out, udf_out.
module param_queue
  import queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int LEN_W = QUEUE_LEN_W
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enq_in,
  input  logic             deq_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic [LEN_W-1:0] len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             ovf_out,
  output logic             udf_out
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             deq_ok;
  logic             enq_ok;
  logic             wr_en;
  logic             rd_en;
  logic [LEN_W-1:0] len_nxt;

  always_comb begin
    deq_ok  = deq_in && !empty_out;
    // A full queue still accepts when a read frees a slot.
    enq_ok  = enq_in && (!full_out || deq_ok);
    wr_en   = enq_ok && !clear_in;
    rd_en   = deq_ok && !clear_in;
    len_nxt = len_out;
    if (clear_in)
      len_nxt = '0;
    else if (enq_ok && !deq_ok)
      len_nxt = len_out + LEN_W'(1);
    else if (deq_ok && !enq_ok)
      len_nxt = len_out - LEN_W'(1);
  end

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clock_10),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len_out   <= '0;
      data_out  <= '0;
      full_out  <= 1'b0;
      empty_out <= 1'b1;
      ovf_out   <= 1'b0;
      udf_out   <= 1'b0;
    end else begin
      len_out   <= len_nxt;
      full_out  <= (len_nxt == FULL_LEN);
      empty_out <= (len_nxt == '0);
      ovf_out   <= !clear_in && enq_in && full_out && !deq_ok;
      udf_out   <= !clear_in && deq_in && empty_out;
      if (clear_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en) begin
          rd_ptr   <= rd_ptr + PW'(1);
          data_out <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_queue.sv
// Directed + random bench for param_queue against a queue-based model.
`timescale 1us/1ns
module tb_param_queue;

  localparam int W = 8;
  localparam int D = 8;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         enq_in;
  logic         deq_in;
  logic         clear_in;
  logic [W-1:0] data_out;
  logic [L-1:0] len_out;
  logic         full_out;
  logic         empty_out;
  logic         ovf_out;
  logic         udf_out;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_udf;

  param_queue #(.WIDTH(W), .DEPTH(D), .LEN_W(L)) dut (
    .clock_10  (clk),
    .reset     (reset),
    .data_in   (data_in),
    .enq_in    (enq_in),
    .deq_in    (deq_in),
    .clear_in  (clear_in),
    .data_out  (data_out),
    .len_out   (len_out),
    .full_out  (full_out),
    .empty_out (empty_out),
    .ovf_out   (ovf_out),
    .udf_out   (udf_out)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  32'(data_out),  32'(m_dout));
    chk({tag, ".len"},   32'(len_out),   32'(mq.size()));
    chk({tag, ".full"},  32'(full_out),  32'(mq.size() == D));
    chk({tag, ".empty"}, 32'(empty_out), 32'(mq.size() == 0));
    chk({tag, ".ovf"},   32'(ovf_out),   32'(m_ovf));
    chk({tag, ".udf"},   32'(udf_out),   32'(m_udf));
  endtask

  // Model: accept rules applied to a plain queue of words.
  task automatic model(input logic e, input logic d, input logic c,
                       input logic [W-1:0] din);
    bit dok, eok;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      dok   = d && (mq.size() > 0);
      eok   = e && ((mq.size() < D) || dok);
      m_ovf = e && !eok;
      m_udf = d && (mq.size() == 0);
      if (dok) m_dout = mq.pop_front();
      if (eok) mq.push_back(din);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c,
                      input logic [W-1:0] din, input string tag);
    enq_in   = e;
    deq_in   = d;
    clear_in = c;
    data_in  = din;
    @(posedge clk);
    #1;
    model(e, d, c, din);
    enq_in   = 1'b0;
    deq_in   = 1'b0;
    clear_in = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = '0;
    enq_in   = 1'b0;
    deq_in   = 1'b0;
    clear_in = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= 8; i++)
      step(1, 0, 0, W'(i * 8'h11), "fill");

    step(1, 0, 0, 8'h99, "ovf");
    step(0, 0, 0, 8'h00, "ovf_end");

    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 8'h00, "drain");
    chk("drain_last", 32'(data_out), 32'h88);

    step(0, 1, 0, 8'h00, "udf");
    step(0, 0, 0, 8'h00, "udf_end");

    for (int i = 0; i < 5; i++)
      step(1, 0, 0, W'($urandom_range(0, 255)), "pre_enq");
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 8'h00, "pre_deq");
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, W'(8'hA0 + i), "wrap_fill");
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 8'h00, "wrap_drain");

    step(1, 1, 0, 8'h5A, "both_empty");
    for (int i = 0; i < 7; i++)
      step(1, 0, 0, W'($urandom_range(0, 255)), "refill");
    step(1, 1, 0, 8'hC3, "both_full");
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 8'h00, "both_drain");
    chk("both_new_last", 32'(data_out), 32'hC3);

    for (int i = 0; i < 3; i++)
      step(1, 0, 0, W'(8'h30 + i), "fl_enq");
    step(1, 1, 1, 8'hEE, "flush");
    step(0, 1, 0, 8'h00, "flush_udf");

    for (int i = 0; i < 4; i++)
      step(1, 0, 0, W'($urandom_range(0, 255)), "mr_enq");
    step(0, 1, 0, 8'h00, "mr_deq");
    step(1, 0, 0, 8'h77, "mr_enq5");
    #20;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    #10;
    reset = 1'b0;
    step(0, 1, 0, 8'h00, "post_reset");

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3),
           W'($urandom_range(0, 255)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
- Parametrised synchronous FIFO. Successor to the fixed 8-bit queue in the deserializer datapath.
- Buffers parallel words produced by the deserializer until the consumer dequeues them.
- Adds configurable width and depth, full/empty flags, overflow/underflow error pulses, synchronous flush, and defined simultaneous enqueue/dequeue.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; power of two, 2..128.
- LEN_W, 8, width of the occupancy count; must satisfy 2**LEN_W > DEPTH.

Ports:
- clock_10 input 1: system clock (10 kHz), rising-edge.
- reset input 1: asynchronous, active-high reset.
- data_in input WIDTH: word to enqueue.
- enq_in input 1: enqueue request, sampled on the rising edge.
- deq_in input 1: dequeue request, sampled on the rising edge.
- clear_in input 1: synchronous flush.
- data_out output WIDTH: last dequeued word, registered.
- len_out output LEN_W: current occupancy, 0..DEPTH.
- full_out output 1: high when len_out == DEPTH.
- empty_out output 1: high when len_out == 0.
- ovf_out output 1: one-cycle pulse when an enqueue is dropped.
- udf_out output 1: one-cycle pulse when a dequeue is rejected.

Behaviour:
- Reset (asynchronous, any time):
  - Read and write pointers = 0, len_out = 0, data_out = 0.
  - empty_out = 1, full_out = 0, ovf_out = 0, udf_out = 0.
  - Storage contents are don't-care.
  - A reset asserted mid-operation discards all queued words; the first edge after release behaves as from empty.
- Storage:
  - Circular buffer of DEPTH x WIDTH.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Accept rules, evaluated each rising edge with the current state:
  - enq_ok = enq_in && (!full || deq_ok)
  - deq_ok = deq_in && !empty
- Enqueue: on enq_ok, mem[wr_ptr] <= data_in; wr_ptr increments.
- Dequeue:
  - On deq_ok, data_out <= mem[rd_ptr]; rd_ptr increments.
  - Latency: the popped word is visible on data_out one edge after the request.
  - data_out holds its value when no dequeue is accepted.
- Length update:
  - +1 on enq_ok only.
  - -1 on deq_ok only.
  - Unchanged when both or neither are accepted.
- Flags: full_out and empty_out are registered and consistent with len_out in the same cycle.
- Simultaneous enqueue and dequeue:
  - When empty: the dequeue is rejected (udf_out pulses), the enqueue is accepted, len_out becomes 1, data_out is unchanged. There is no fall-through.
  - When full: both are accepted; len_out stays DEPTH; the write lands in the slot freed by the read.
  - Otherwise: both are accepted; len_out is unchanged.
- ovf_out: pulses for the cycle after an edge where enq_in=1, full=1 and deq_ok=0. The word is dropped and state is unchanged.
- udf_out: pulses for the cycle after an edge where deq_in=1 and empty=1. data_out is unchanged.
- Flush:
  - clear_in has priority over enq_in and deq_in.
  - Pointers and len_out go to 0, empty_out = 1, data_out is held.
  - No ovf_out or udf_out pulse is generated on a flush edge.
- Reads from unwritten or stale storage never reach data_out, because empty blocks the read.

Decomposition:
- Package queue_pkg holds:
  - Default constants QUEUE_WIDTH = 8, QUEUE_DEPTH = 8, QUEUE_LEN_W = 8.
  - A function computing the pointer width, clog2(DEPTH).
- Sub-module queue_mem: DEPTH x WIDTH register array with a synchronous write port and an indexed read port.
- param_queue contains the pointers, count, flags and control logic.

Test Plan:
- Reset, then enqueue 8'h11..8'h88 on consecutive edges (DEPTH=8) -> len_out counts 1..8; full_out=1 after the 8th; empty_out=0 throughout.
- With the queue full, enqueue 8'h99 -> ovf_out pulses for 1 cycle; len_out stays 8. Then dequeue 8 times -> data_out shows 11,22,...,88 in order, each one edge after its request; the 99 never appears; empty_out=1 at the end.
- Dequeue while empty -> udf_out pulses for 1 cycle; data_out holds 8'h88; len_out stays 0.
- Wrap-around: enqueue 5, dequeue 5, then enqueue 8'hA0..8'hA7 -> full_out=1; dequeue all -> A0..A7 in order across the pointer wrap.
- Simultaneous enq+deq:
  - Empty with data_in=8'h5A -> udf_out=1, len_out=1.
  - Full -> len_out stays 8; the new word emerges after the 7 older ones.
- Flush: enqueue 3 words, then pulse clear_in together with enq_in -> len_out=0, empty_out=1, no ovf_out or udf_out, data_out held.
- Reset mid-operation: assert reset mid-cycle with len_out=4 -> all outputs immediately take their reset values.
